beamformer_sequencer: RTL and testbench

Top-level phase controller for the 8-channel delay-and-sum beamformer. It replaces the ad-hoc control process with a single reset-clean FSM. The FSM steps the array through signal load, filtering, filter flush, beamforming slice scheduling and result summing/readout. It drives the shared signal RAM address, the common channel control bus (reset, start, read-in/sum-out addresses, slice state, sample index) and a valid/ready handshake toward the UART packer.

---
 rtl/beamformer_sequencer_if.sv | 42 ++++
 rtl/beamformer_sequencer.sv | 177 +++++++++++++++++
 tb/tb_beamformer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beamformer_sequencer_if.sv
// Control bus between the beamformer sequencer and the rest of the array.
// Carries the start/status inputs (go, valid_all, done_all, out_ready) and
// every control output the sequencer drives: signal RAM read port, the
// common channel control bus, sum-out RAM addressing and the valid/ready
// handshake toward the UART packer.
//   master : sequencer side (drives the control outputs)
//   slave  : channel array / packer / testbench side
interface beamformer_sequencer_if;
  logic        go;
  logic        valid_all;
  logic        done_all;
  logic        out_ready;
  logic [10:0] signal_addr;
  logic        signal_rden;
  logic        chan_rst;
  logic        chan_start;
  logic [10:0] readin_addr;
  logic        output_read_en;
  logic        startbeamformer;
  logic [1:0]  slice_state;
  logic [15:0] sample_index;
  logic        sumouten;
  logic [9:0]  sumout_addr;
  logic        sum_capture;
  logic        out_valid;
  logic        busy;
  logic        done;

  modport master (
    input  go, valid_all, done_all, out_ready,
    output signal_addr, signal_rden, chan_rst, chan_start, readin_addr,
           output_read_en, startbeamformer, slice_state, sample_index,
           sumouten, sumout_addr, sum_capture, out_valid, busy, done
  );

  modport slave (
    output go, valid_all, done_all, out_ready,
    input  signal_addr, signal_rden, chan_rst, chan_start, readin_addr,
           output_read_en, startbeamformer, slice_state, sample_index,
           sumouten, sumout_addr, sum_capture, out_valid, busy, done
  );
endinterface

// File: rtl/beamformer_sequencer.sv
// Phase controller for the 8-channel delay-and-sum beamformer.
// Steps the array through signal load, filtering, filter flush, beamforming
// slice scheduling and summed-result readout.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - control bus (master side), see beamformer_sequencer_if
// Every control output is a flop: the next-state process computes the next
// value of each output alongside the next state, so nothing on the bus is
// combinational from an input. Outputs not touched in a state hold.
module beamformer_sequencer #(
  parameter int SIG_DEPTH = 2048,
  parameter int FLUSH_CYC = 6,
  parameter int OUT_LEN   = 540
) (
  input  logic clk,
  input  logic rst_n,
  beamformer_sequencer_if.master bus
);
  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYC - 1);
  localparam logic [10:0]    SIG_LAST   = 11'(SIG_DEPTH - 1);
  localparam logic [9:0]     OUT_LAST   = 10'(OUT_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, FILTER, FLUSH, BEAM, SUM_ADDR, SUM_WAIT, SUM_OUT, DONE
  } state_t;

  typedef struct packed {
    logic [10:0] signal_addr;
    logic        signal_rden;
    logic        chan_rst;
    logic        chan_start;
    logic [10:0] readin_addr;
    logic        output_read_en;
    logic        startbeamformer;
    logic [1:0]  slice_state;
    logic [15:0] sample_index;
    logic        sumouten;
    logic [9:0]  sumout_addr;
    logic        sum_capture;
    logic        out_valid;
    logic        busy;
    logic        done;
  } ctl_t;

  // sample_index idles at all-ones so the first increment lands on 0
  localparam ctl_t CTL_RST = '{sample_index: 16'hFFFF, default: '0};

  state_t         state_q, state_d;
  ctl_t           q, nx;
  logic [FCW-1:0] flush_q, flush_d;
  logic           rel_q;  // low during the first clock after reset release

  // readin_addr saturates instead of wrapping so a long valid_all burst can
  // never alias back onto low addresses within a run
  function automatic logic [10:0] rd_inc(input logic [10:0] a);
    return (a == 11'h7FF) ? a : a + 11'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flush_q <= '0;
      rel_q   <= 1'b0;
      q       <= CTL_RST;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      rel_q   <= 1'b1;
      q       <= nx;
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_d        = flush_q;
    nx             = q;
    nx.sum_capture = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.go && rel_q) begin
          state_d        = LOAD;
          nx.signal_rden = 1'b1;
          nx.chan_rst    = 1'b1;
          nx.signal_addr = '0;
          nx.readin_addr = '0;
          nx.busy        = 1'b1;
          nx.done        = 1'b0;
        end
      end
      LOAD: begin
        state_d        = FILTER;
        nx.chan_start  = 1'b1;
        nx.signal_rden = 1'b1;
        flush_d        = '0;
      end
      FILTER: begin
        if (bus.valid_all) nx.readin_addr = rd_inc(q.readin_addr);
        if (q.signal_addr == SIG_LAST) state_d = FLUSH;
        else nx.signal_addr = q.signal_addr + 11'd1;
      end
      FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d            = BEAM;
          nx.readin_addr     = '0;
          nx.chan_rst        = 1'b0;
          nx.chan_start      = 1'b0;
          nx.signal_rden     = 1'b0;
          nx.startbeamformer = 1'b1;
          nx.output_read_en  = 1'b1;
          nx.slice_state     = 2'd0;
        end else begin
          flush_d = flush_q + FCW'(1);
          if (bus.valid_all) nx.readin_addr = rd_inc(q.readin_addr);
        end
      end
      BEAM: begin
        // done_all wins over the slice update in the same cycle
        if (bus.done_all) begin
          state_d            = SUM_ADDR;
          nx.sumout_addr     = '0;
          nx.startbeamformer = 1'b0;
          nx.output_read_en  = 1'b0;
          nx.sumouten        = 1'b1;
        end else begin
          nx.slice_state = q.slice_state + 2'd1;
          if (q.slice_state != 2'd0) nx.sample_index = q.sample_index + 16'd1;
          if (q.slice_state == 2'd3) nx.readin_addr  = rd_inc(q.readin_addr);
        end
      end
      SUM_ADDR: begin
        // address is on the RAM this cycle; data appears next cycle
        state_d        = SUM_WAIT;
        nx.sum_capture = 1'b1;
      end
      SUM_WAIT: begin
        state_d      = SUM_OUT;
        nx.out_valid = 1'b1;
      end
      SUM_OUT: begin
        if (bus.out_ready) begin
          nx.out_valid = 1'b0;
          if (q.sumout_addr == OUT_LAST) begin
            state_d         = DONE;
            nx.sumout_addr  = '0;
            nx.sumouten     = 1'b0;
            nx.busy         = 1'b0;
            nx.done         = 1'b1;
            nx.sample_index = 16'hFFFF;
            nx.slice_state  = 2'd0;
          end else begin
            state_d        = SUM_ADDR;
            nx.sumout_addr = q.sumout_addr + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.signal_addr     = q.signal_addr;
  assign bus.signal_rden     = q.signal_rden;
  assign bus.chan_rst        = q.chan_rst;
  assign bus.chan_start      = q.chan_start;
  assign bus.readin_addr     = q.readin_addr;
  assign bus.output_read_en  = q.output_read_en;
  assign bus.startbeamformer = q.startbeamformer;
  assign bus.slice_state     = q.slice_state;
  assign bus.sample_index    = q.sample_index;
  assign bus.sumouten        = q.sumouten;
  assign bus.sumout_addr     = q.sumout_addr;
  assign bus.sum_capture     = q.sum_capture;
  assign bus.out_valid       = q.out_valid;
  assign bus.busy            = q.busy;
  assign bus.done            = q.done;
endmodule

// File: tb/tb_beamformer_sequencer.sv
// Bench for beamformer_sequencer: phase-level model with closed-form
// expectations per phase, a per-cycle compare, and directed literal checks.
module tb_beamformer_sequencer;
  localparam int SD = 2048;
  localparam int FC = 6;
  localparam int OL = 540;

  localparam int P_IDLE = 0, P_LOAD = 1, P_FILT = 2, P_FLSH = 3, P_BEAM = 4,
                 P_SA = 5, P_SW = 6, P_SO = 7, P_DONE = 8;

  typedef struct packed {
    logic [10:0] signal_addr;
    logic        signal_rden;
    logic        chan_rst;
    logic        chan_start;
    logic [10:0] readin_addr;
    logic        output_read_en;
    logic        startbeamformer;
    logic [1:0]  slice_state;
    logic [15:0] sample_index;
    logic        sumouten;
    logic [9:0]  sumout_addr;
    logic        sum_capture;
    logic        out_valid;
    logic        busy;
    logic        done;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  beamformer_sequencer_if bif();
  beamformer_sequencer #(.SIG_DEPTH(SD), .FLUSH_CYC(FC), .OUT_LEN(OL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int ph = P_IDLE, n = 0, vcnt = 0, w = 0, beam_n = 0;
  bit rel = 1'b0;

  function automatic logic [15:0] si_after(input int k);
    // slices 1..3 of each group of four advance the index once each
    return 16'hFFFF + 16'(k - (k + 3) / 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; n = 0; vcnt = 0; w = 0; rel = 1'b0;
    end else begin
      case (ph)
        P_IDLE, P_DONE: if (bif.go && rel) ph = P_LOAD;
        P_LOAD: begin ph = P_FILT; n = 0; vcnt = 0; end
        P_FILT: begin
          if (bif.valid_all) vcnt++;
          if (n == SD - 1) begin ph = P_FLSH; n = 0; end else n++;
        end
        P_FLSH: begin
          if (n == FC - 1) begin ph = P_BEAM; n = 0; end
          else begin if (bif.valid_all) vcnt++; n++; end
        end
        P_BEAM: begin
          if (bif.done_all) begin beam_n = n; w = 0; ph = P_SA; end else n++;
        end
        P_SA: ph = P_SW;
        P_SW: ph = P_SO;
        P_SO: if (bif.out_ready) begin
          if (w == OL - 1) ph = P_DONE; else begin w++; ph = P_SA; end
        end
        default: ph = P_IDLE;
      endcase
      rel = 1'b1;
    end
  end

  function automatic out_t expv();
    out_t e;
    e = '0;
    e.sample_index = 16'hFFFF;
    case (ph)
      P_LOAD: begin e.signal_rden = 1; e.chan_rst = 1; e.busy = 1; end
      P_FILT, P_FLSH: begin
        e.signal_addr = (ph == P_FILT) ? 11'(n) : 11'(SD - 1);
        e.signal_rden = 1; e.chan_rst = 1; e.chan_start = 1; e.busy = 1;
        e.readin_addr = (vcnt > 2047) ? 11'd2047 : 11'(vcnt);
      end
      P_BEAM: begin
        e.signal_addr = 11'(SD - 1);
        e.readin_addr = 11'(n / 4);
        e.startbeamformer = 1; e.output_read_en = 1; e.busy = 1;
        e.slice_state = 2'(n % 4);
        e.sample_index = si_after(n);
      end
      P_SA, P_SW, P_SO: begin
        e.signal_addr = 11'(SD - 1);
        e.readin_addr = 11'(beam_n / 4);
        e.slice_state = 2'(beam_n % 4);
        e.sample_index = si_after(beam_n);
        e.sumouten = 1; e.busy = 1;
        e.sumout_addr = 10'(w);
        e.sum_capture = (ph == P_SW);
        e.out_valid = (ph == P_SO);
      end
      P_DONE: begin
        e.signal_addr = 11'(SD - 1);
        e.readin_addr = 11'(beam_n / 4);
        e.done = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic out_t actv();
    out_t a;
    a = '{bif.signal_addr, bif.signal_rden, bif.chan_rst, bif.chan_start,
          bif.readin_addr, bif.output_read_en, bif.startbeamformer,
          bif.slice_state, bif.sample_index, bif.sumouten, bif.sumout_addr,
          bif.sum_capture, bif.out_valid, bif.busy, bif.done};
    return a;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    out_t e, a;
    e = expv();
    a = actv();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs t=%0t phase=%0d got=%h expected=%h", $time, ph, a, e);
    end
  end

  // ---------------- pulse monitor ----------------
  int cyc = 0, ov_cnt = 0, cap_cnt = 0, last_rise = 0, neq3 = 0, lt3 = 0;
  bit ov_prev = 1'b0, have_rise = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (bif.sum_capture === 1'b1) cap_cnt++;
    if (bif.out_valid === 1'b1 && !ov_prev) begin
      ov_cnt++;
      if (have_rise) begin
        if (cyc - last_rise != 3) neq3++;
        if (cyc - last_rise < 3) lt3++;
      end
      last_rise = cyc;
      have_rise = 1'b1;
    end
    ov_prev = (bif.out_valid === 1'b1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  int ov0, cap0, n30, l30;

  initial begin
    rst_n = 1'b1;
    bif.go = 0; bif.valid_all = 0; bif.done_all = 0; bif.out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sample_index", bif.sample_index, 16'hFFFF);
    chk("rst_busy", bif.busy, 0);
    chk("rst_signal_addr", bif.signal_addr, 0);
    tick(); tick();
    // go during the release cycle must be ignored
    rst_n = 1'b1; bif.go = 1;
    tick();
    chk("release_go_ignored", bif.busy, 0);
    tick();
    chk("load_chan_rst", bif.chan_rst, 1);
    chk("load_rden", bif.signal_rden, 1);
    bif.go = 0;

    // ---- run A: valid_all always high, out_ready always high ----
    bif.valid_all = 1;
    tick();
    chk("filter_first_addr", bif.signal_addr, 0);
    repeat (SD - 1) tick();
    chk("filter_last_addr", bif.signal_addr, 2047);
    tick();
    repeat (FC - 1) tick();
    chk("flush_end_readin_sat", bif.readin_addr, 2047);
    chk("flush_signal_hold", bif.signal_addr, 2047);
    tick();
    chk("beam_entry_readin", bif.readin_addr, 0);
    chk("beam_entry_startbf", bif.startbeamformer, 1);
    chk("beam_entry_chan_rst", bif.chan_rst, 0);
    bif.valid_all = 0;
    repeat (12) tick();
    bif.done_all = 1;
    tick();
    bif.done_all = 0;
    chk("beam12_sample_index", bif.sample_index, 8);
    chk("beam12_readin", bif.readin_addr, 3);
    chk("beam12_slice", bif.slice_state, 0);
    chk("sum_addr_start", bif.sumout_addr, 0);
    chk("sum_sumouten", bif.sumouten, 1);
    ov0 = ov_cnt; cap0 = cap_cnt; n30 = neq3;
    bif.out_ready = 1;
    repeat (3 * OL) tick();
    chk("runA_done", bif.done, 1);
    chk("runA_busy", bif.busy, 0);
    chk("runA_sumout_addr", bif.sumout_addr, 0);
    chk("runA_sample_reset", bif.sample_index, 16'hFFFF);
    chk("runA_ov_pulses", ov_cnt - ov0, OL);
    chk("runA_cap_pulses", cap_cnt - cap0, OL);
    chk("runA_spacing_not3", neq3 - n30, 0);

    // ---- run B: valid_all toggling, backpressure at word 100 ----
    bif.go = 1;
    tick();
    bif.go = 0;
    chk("runB_load_done_low", bif.done, 0);
    chk("runB_load_readin", bif.readin_addr, 0);
    tick();
    for (int k = 0; k < SD; k++) begin
      bif.valid_all = (k % 2 == 0);
      tick();
    end
    bif.valid_all = 0;
    chk("toggle_readin", bif.readin_addr, 1024);
    repeat (FC) tick();
    chk("runB_beam_readin", bif.readin_addr, 0);
    repeat (3) tick();
    bif.done_all = 1;
    tick();
    bif.done_all = 0;
    chk("beam3_sample_index", bif.sample_index, 1);
    chk("beam3_slice", bif.slice_state, 3);
    ov0 = ov_cnt; cap0 = cap_cnt; l30 = lt3;
    bif.out_ready = 1;
    repeat (3 * 100) tick();
    chk("stall_addr_pre", bif.sumout_addr, 100);
    repeat (2) tick();
    bif.out_ready = 0;
    bif.go = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_out_valid", bif.out_valid, 1);
      chk("stall_addr", bif.sumout_addr, 100);
      chk("stall_busy", bif.busy, 1);
    end
    bif.go = 0;
    bif.out_ready = 1;
    tick();
    chk("stall_release_addr", bif.sumout_addr, 101);
    chk("stall_release_valid", bif.out_valid, 0);
    repeat (3 * (OL - 101)) tick();
    chk("runB_done", bif.done, 1);
    chk("runB_ov_pulses", ov_cnt - ov0, OL);
    chk("runB_cap_pulses", cap_cnt - cap0, OL);
    chk("runB_spacing_lt3", lt3 - l30, 0);

    // ---- run C: reset in the middle of BEAM ----
    bif.go = 1;
    tick();
    bif.go = 0;
    bif.valid_all = 1;
    tick();
    repeat (SD) tick();
    repeat (FC) tick();
    repeat (2) tick();
    chk("midbeam_slice", bif.slice_state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sample_index", bif.sample_index, 16'hFFFF);
    chk("midrst_slice", bif.slice_state, 0);
    chk("midrst_startbf", bif.startbeamformer, 0);
    chk("midrst_busy", bif.busy, 0);
    chk("midrst_signal_addr", bif.signal_addr, 0);
    bif.valid_all = 0;
    tick(); tick();
    rst_n = 1'b1; bif.go = 1;
    tick();
    chk("midrst_release_ignored", bif.busy, 0);
    tick();
    chk("midrst_go_load", bif.chan_rst, 1);
    chk("midrst_go_busy", bif.busy, 1);
    bif.go = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
